// File: rtl/outport_display_driver.sv
// Shows the last word written to OUTPORT on two seven-segment digits, one byte per page.
// A page timer steps through the four bytes; decimal points flag Run status and page 0.
module outport_display_driver #(
  parameter int PAGE_CYCLES = 50000000,
  parameter bit AUTO_PAGE   = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] outportData,
  input  logic        outportWrite,
  input  logic        Run,
  input  logic        Blank,
  output logic [7:0]  seg0out,
  output logic [7:0]  seg1out,
  output logic [1:0]  page
);

  localparam int              TW         = $clog2(PAGE_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(PAGE_CYCLES - 1);
  localparam logic [7:0]      SEG_OFF    = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [31:0]   value_q, value_d;
  logic [1:0]    page_q, page_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    seg0_q, seg0_d;
  logic [7:0]    seg1_q, seg1_d;

  logic [7:0]    shown_byte;
  logic [7:0]    seg0_raw, seg1_raw;

  // Active-high segment pattern, bit0..6 = a..g.
  function automatic logic [6:0] hex_pattern(input logic [3:0] digit);
    case (digit)
      4'h0:    hex_pattern = 7'h3F;
      4'h1:    hex_pattern = 7'h06;
      4'h2:    hex_pattern = 7'h5B;
      4'h3:    hex_pattern = 7'h4F;
      4'h4:    hex_pattern = 7'h66;
      4'h5:    hex_pattern = 7'h6D;
      4'h6:    hex_pattern = 7'h7D;
      4'h7:    hex_pattern = 7'h07;
      4'h8:    hex_pattern = 7'h7F;
      4'h9:    hex_pattern = 7'h6F;
      4'hA:    hex_pattern = 7'h77;
      4'hB:    hex_pattern = 7'h7C;
      4'hC:    hex_pattern = 7'h39;
      4'hD:    hex_pattern = 7'h5E;
      4'hE:    hex_pattern = 7'h79;
      default: hex_pattern = 7'h71;
    endcase
  endfunction

  // A write restarts the display at page 0 and takes priority over the page timer.
  always_comb begin
    value_d = value_q;
    page_d  = page_q;
    timer_d = timer_q;
    if (outportWrite) begin
      value_d = outportData;
      page_d  = 2'd0;
      timer_d = '0;
    end else if (AUTO_PAGE) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        page_d  = page_q + 2'd1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    shown_byte = value_q[8*page_q +: 8];
    seg1_raw   = {page_q == 2'd0, hex_pattern(shown_byte[7:4])};
    seg0_raw   = {Run,            hex_pattern(shown_byte[3:0])};
    seg1_d     = Blank ? SEG_OFF : (ACTIVE_LOW ? ~seg1_raw : seg1_raw);
    seg0_d     = Blank ? SEG_OFF : (ACTIVE_LOW ? ~seg0_raw : seg0_raw);
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      value_q <= '0;
      page_q  <= 2'd0;
      timer_q <= '0;
      seg0_q  <= SEG_OFF;
      seg1_q  <= SEG_OFF;
    end else begin
      value_q <= value_d;
      page_q  <= page_d;
      timer_q <= timer_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
    end
  end

  assign seg0out = seg0_q;
  assign seg1out = seg1_q;
  assign page    = page_q;

endmodule

// File: tb/tb_outport_display_driver.sv
// Directed bench for outport_display_driver with a 4-cycle page and active-low segments.
module tb_outport_display_driver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] outportData;
  logic        outportWrite;
  logic        Run;
  logic        Blank;
  logic [7:0]  seg0out;
  logic [7:0]  seg1out;
  logic [1:0]  page;

  int checks = 0;
  int errors = 0;

  outport_display_driver #(
    .PAGE_CYCLES(4),
    .AUTO_PAGE  (1'b1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .outportData (outportData),
    .outportWrite(outportWrite),
    .Run         (Run),
    .Blank       (Blank),
    .seg0out     (seg0out),
    .seg1out     (seg1out),
    .page        (page)
  );

  always #5 Clock = ~Clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_segs(input string tag, input logic [7:0] exp1, input logic [7:0] exp0);
    check({tag, "_seg1"}, {24'h0, seg1out}, {24'h0, exp1});
    check({tag, "_seg0"}, {24'h0, seg0out}, {24'h0, exp0});
  endtask

  initial begin
    Reset        = 1'b1;
    outportData  = 32'h0;
    outportWrite = 1'b0;
    Run          = 1'b0;
    Blank        = 1'b0;

    // Reset held two cycles: all segments off.
    tick(1);
    check_segs("reset1", 8'hFF, 8'hFF);
    tick(1);
    check_segs("reset2", 8'hFF, 8'hFF);
    check("reset_page", {30'h0, page}, 32'd0);

    // Released, no writes: "0.0" with page-0 dp on seg1.
    Reset = 1'b0;
    tick(1);
    check_segs("idle", 8'h40, 8'hC0);

    // Write 0x88: one edge to capture, one edge to decode.
    outportData  = 32'h0000_0088;
    outportWrite = 1'b1;
    tick(1);
    outportWrite = 1'b0;
    check_segs("pre_decode", 8'h40, 8'hC0);
    tick(1);
    check_segs("w88", 8'h00, 8'h80);
    check("w88_page", {30'h0, page}, 32'd0);

    // Write 0x12345678 and walk the pages (capture edge = N).
    outportData  = 32'h1234_5678;
    outportWrite = 1'b1;
    tick(1);                                  // N
    outportWrite = 1'b0;
    tick(1);                                  // N+1
    check_segs("p0", 8'h78, 8'h80);
    tick(3);                                  // N+4
    check("p1_page", {30'h0, page}, 32'd1);
    tick(1);                                  // N+5
    check_segs("p1", 8'h92, 8'h82);
    tick(3);                                  // N+8
    check("p2_page", {30'h0, page}, 32'd2);
    tick(1);                                  // N+9
    check_segs("p2", 8'hB0, 8'h99);
    tick(3);                                  // N+12
    check("p3_page", {30'h0, page}, 32'd3);
    tick(1);                                  // N+13
    check_segs("p3", 8'hF9, 8'hA4);
    tick(3);                                  // N+16
    check("wrap_page", {30'h0, page}, 32'd0);
    tick(1);                                  // N+17
    check_segs("wrap", 8'h78, 8'h80);

    // Write coinciding with page-2 terminal count: write wins.
    tick(10);                                 // N+27, timer at terminal
    check("tc_page", {30'h0, page}, 32'd2);
    outportData  = 32'hDEAD_BEEF;
    outportWrite = 1'b1;
    tick(1);                                  // N+28
    outportWrite = 1'b0;
    check("tc_write_page", {30'h0, page}, 32'd0);
    tick(1);                                  // N+29
    check_segs("dead_p0", 8'h06, 8'h8E);
    tick(2);                                  // N+31
    check("restart_hold", {30'h0, page}, 32'd0);
    tick(1);                                  // N+32
    check("restart_adv", {30'h0, page}, 32'd1);

    // Run and Blank alternate; page 1 shows 0xBE.
    Run = 1'b1;
    tick(1);                                  // N+33
    check_segs("run_on", 8'h83, 8'h06);
    Run   = 1'b0;
    Blank = 1'b1;
    tick(1);                                  // N+34
    check_segs("blank1", 8'hFF, 8'hFF);
    Blank = 1'b0;
    Run   = 1'b1;
    tick(1);                                  // N+35
    check_segs("run_on2", 8'h83, 8'h06);
    Run   = 1'b0;
    Blank = 1'b1;
    tick(1);                                  // N+36
    check_segs("blank2", 8'hFF, 8'hFF);
    check("blank_page_adv", {30'h0, page}, 32'd2);
    Blank = 1'b0;
    tick(1);                                  // N+37
    check_segs("after_blank", 8'h88, 8'hA1);

    // Reset in the middle of page 3 discards the value.
    tick(4);                                  // N+41
    check("mid_p3_page", {30'h0, page}, 32'd3);
    Reset = 1'b1;
    tick(1);
    check("rst_page", {30'h0, page}, 32'd0);
    check_segs("rst_mid", 8'hFF, 8'hFF);
    Reset = 1'b0;
    tick(1);
    check_segs("rst_after", 8'h40, 8'hC0);
    check("rst_after_page", {30'h0, page}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
